// File: rtl/dct_quant_pkg.sv
// dct_quant_pkg: shared widths, default JPEG luminance reciprocal table
// and the output saturation helper for the row quantizer.
package dct_quant_pkg;

    localparam int DCTQ_LANES = 8;
    localparam int DCTQ_ROWS  = 8;
    localparam int IN_BW      = 12;
    localparam int OUT_BW     = 8;
    localparam int RECIP_BW   = 16;
    localparam int FRAC_BW    = 16;
    localparam int PROD_BW    = IN_BW + RECIP_BW + 1;

    localparam logic signed [PROD_BW-1:0] DCTQ_HALF =
        PROD_BW'(1 << (FRAC_BW - 1));
    localparam logic signed [PROD_BW-1:0] DCTQ_SAT_MAX =
        PROD_BW'(127);
    localparam logic signed [PROD_BW-1:0] DCTQ_SAT_MIN =
        PROD_BW'(-128);

    // round(65536/Q) of the JPEG luminance table, index row*8+col
    localparam logic [RECIP_BW-1:0] DCTQ_RECIP [64] = '{
        16'd4096, 16'd5958, 16'd6554, 16'd4096,
        16'd2731, 16'd1638, 16'd1285, 16'd1074,
        16'd5461, 16'd5461, 16'd4681, 16'd3449,
        16'd2521, 16'd1130, 16'd1092, 16'd1192,
        16'd4681, 16'd5041, 16'd4096, 16'd2731,
        16'd1638, 16'd1150, 16'd950,  16'd1170,
        16'd4681, 16'd3855, 16'd2979, 16'd2260,
        16'd1285, 16'd753,  16'd819,  16'd1057,
        16'd3641, 16'd2979, 16'd1771, 16'd1170,
        16'd964,  16'd601,  16'd636,  16'd851,
        16'd2731, 16'd1872, 16'd1192, 16'd1024,
        16'd809,  16'd630,  16'd580,  16'd712,
        16'd1337, 16'd1024, 16'd840,  16'd753,
        16'd636,  16'd542,  16'd546,  16'd649,
        16'd910,  16'd712,  16'd690,  16'd669,
        16'd585,  16'd655,  16'd636,  16'd662
    };

    function automatic logic signed [OUT_BW-1:0] dctq_sat(
        input logic signed [PROD_BW-1:0] v
    );
        logic signed [OUT_BW-1:0] r;
        if (v > DCTQ_SAT_MAX) begin
            r = 8'sd127;
        end else if (v < DCTQ_SAT_MIN) begin
            r = -8'sd128;
        end else begin
            r = v[OUT_BW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dct_quant_if.sv
// dct_quant_if: row stream in, quantized row stream out, and the
// reciprocal table write port.
interface dct_quant_if;
    import dct_quant_pkg::*;

    logic                           i_valid;
    logic                           i_sof;
    logic [DCTQ_LANES*IN_BW-1:0]    i_coef;
    logic                           o_valid;
    logic [DCTQ_LANES*OUT_BW-1:0]   o_coef;
    logic [2:0]                     o_row;
    logic                           o_last;
    logic                           tbl_we;
    logic [5:0]                     tbl_addr;
    logic [RECIP_BW-1:0]            tbl_data;

    modport master (
        output i_valid, i_sof, i_coef,
        output tbl_we, tbl_addr, tbl_data,
        input  o_valid, o_coef, o_row, o_last
    );

    modport slave (
        input  i_valid, i_sof, i_coef,
        input  tbl_we, tbl_addr, tbl_data,
        output o_valid, o_coef, o_row, o_last
    );

endinterface

// File: rtl/dct_quant_lane.sv
// dct_quant_lane: one column's multiply (stage 1) and
// round-half-up plus 8-bit saturation (stage 2).
module dct_quant_lane
    import dct_quant_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_en1,
    input  logic                       i_en2,
    input  logic signed [IN_BW-1:0]    i_coef,
    input  logic [RECIP_BW-1:0]        i_recip,
    output logic signed [OUT_BW-1:0]   o_q
);

    logic signed [PROD_BW-1:0] p_d, p_q;
    logic signed [PROD_BW-1:0] rnd;
    logic signed [OUT_BW-1:0]  q_d, q_q;

    // stage 1: signed coef times zero-extended reciprocal
    always_comb begin
        p_d = p_q;
        if (i_en1) begin
            p_d = PROD_BW'(i_coef)
                * PROD_BW'($signed({1'b0, i_recip}));
        end
    end

    // stage 2: add half, arithmetic shift, clamp to 8 bits
    always_comb begin
        rnd = p_q + DCTQ_HALF;
        q_d = q_q;
        if (i_en2) begin
            q_d = dctq_sat(rnd >>> FRAC_BW);
        end
    end

    // stage registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_q <= '0;
            q_q <= '0;
        end else begin
            p_q <= p_d;
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/dct_quantizer.sv
// dct_quantizer: 8-lane row quantizer with row framing, latency 2.
// Macro DCTQ_TABLE_LOAD_EN makes the reciprocal table writable.
module dct_quantizer
    import dct_quant_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    dct_quant_if.slave  bus
);

    logic [2:0] cnt_d, cnt_q;
    logic [2:0] row_idx;
    logic       v1_d, v1_q;
    logic [2:0] row1_d, row1_q;
    logic       vo_d, vo_q;
    logic [2:0] rowo_d, rowo_q;
    logic       last_d, last_q;

    logic [RECIP_BW-1:0]             tbl_rd [64];
    logic signed [OUT_BW-1:0]        lane_q [DCTQ_LANES];
    logic [DCTQ_LANES*OUT_BW-1:0]    coef_o;

    // row index for the incoming row; sof restarts the block
    always_comb begin
        row_idx = bus.i_sof ? 3'd0 : cnt_q;
        cnt_d   = cnt_q;
        if (bus.i_valid) begin
            cnt_d = row_idx + 3'd1;
        end
    end

    // framing pipeline alongside the lane datapath
    always_comb begin
        v1_d   = bus.i_valid;
        row1_d = bus.i_valid ? row_idx : row1_q;
        vo_d   = v1_q;
        rowo_d = v1_q ? row1_q : rowo_q;
        last_d = v1_q && (row1_q == 3'(DCTQ_ROWS - 1));
    end

    // counter and framing registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            v1_q   <= 1'b0;
            row1_q <= '0;
            vo_q   <= 1'b0;
            rowo_q <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            v1_q   <= v1_d;
            row1_q <= row1_d;
            vo_q   <= vo_d;
            rowo_q <= rowo_d;
            last_q <= last_d;
        end
    end

`ifdef DCTQ_TABLE_LOAD_EN
    logic [RECIP_BW-1:0] tbl_d [64];
    logic [RECIP_BW-1:0] tbl_q [64];

    // table write; readers see the new value from the next edge
    always_comb begin
        tbl_d = tbl_q;
        if (bus.tbl_we) begin
            tbl_d[bus.tbl_addr] = bus.tbl_data;
        end
        tbl_rd = tbl_q;
    end

    // table storage, reloaded with JPEG defaults on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            tbl_q <= DCTQ_RECIP;
        end else begin
            tbl_q <= tbl_d;
        end
    end
`else
    logic unused_tbl;

    // fixed table; write port has no effect in this build
    always_comb begin
        tbl_rd = DCTQ_RECIP;
    end

    assign unused_tbl = ^{bus.tbl_we, bus.tbl_addr, bus.tbl_data};
`endif

    for (genvar k = 0; k < DCTQ_LANES; k++) begin : g_lane
        dct_quant_lane u_lane (
            .clk     (clk),
            .reset   (reset),
            .i_en1   (bus.i_valid),
            .i_en2   (v1_q),
            .i_coef  (bus.i_coef[k*IN_BW +: IN_BW]),
            .i_recip (tbl_rd[{row_idx, 3'(k)}]),
            .o_q     (lane_q[k])
        );
    end

    // pack lane outputs into the 64-bit memory word
    always_comb begin
        coef_o = '0;
        for (int k = 0; k < DCTQ_LANES; k++) begin
            coef_o[k*OUT_BW +: OUT_BW] = lane_q[k];
        end
    end

    assign bus.o_coef  = coef_o;
    assign bus.o_valid = vo_q;
    assign bus.o_row   = rowo_q;
    assign bus.o_last  = last_q;

endmodule

// File: tb/tb_dct_quantizer.sv
// tb_dct_quantizer: directed vectors and framing sequences for
// dct_quantizer, with hand-computed expected outputs.
module tb_dct_quantizer;
    import dct_quant_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dct_quant_if bus ();

    dct_quantizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int c0;
        int c1;
        int e0;
        int e1;
    } vec_t;

    vec_t vecs [7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] pack_in(int c0, int c1, int c7);
        logic [95:0] v;
        v = '0;
        v[11:0]  = 12'(c0);
        v[23:12] = 12'(c1);
        v[95:84] = 12'(c7);
        return v;
    endfunction

    function automatic logic [63:0] pack_out(int e0, int e1);
        logic [63:0] v;
        v = '0;
        v[7:0]  = 8'(e0);
        v[15:8] = 8'(e1);
        return v;
    endfunction

    task automatic drive(input logic v, input logic s,
                         input logic [95:0] c);
        bus.i_valid = v;
        bus.i_sof   = s;
        bus.i_coef  = c;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, '0);
    endtask

    // one row 0 through the pipe, lane 0 result compared
    task automatic one_row(input string name, input int c0,
                           input int e0);
        drive(1'b1, 1'b1, pack_in(c0, 0, 0));
        tick;
        idle;
        tick;
        chk(name, 64'(bus.o_coef), pack_out(e0, 0));
    endtask

    logic sofs [5];
    int   rexp [5];

    initial begin
        vecs[0] = '{c0: 100,   c1: 0,     e0: 6,    e1: 0};
        vecs[1] = '{c0: -100,  c1: 0,     e0: -6,   e1: 0};
        vecs[2] = '{c0: 2047,  c1: 2047,  e0: 127,  e1: 127};
        vecs[3] = '{c0: -2048, c1: -2048, e0: -128, e1: -128};
        vecs[4] = '{c0: 8,     c1: 11,    e0: 1,    e1: 1};
        vecs[5] = '{c0: -8,    c1: -11,   e0: 0,    e1: -1};
        vecs[6] = '{c0: 7,     c1: 0,     e0: 0,    e1: 0};
        sofs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rexp = '{0, 1, 2, 0, 1};

        bus.tbl_we   = 1'b0;
        bus.tbl_addr = '0;
        bus.tbl_data = '0;
        idle;
        reset = 1'b0;
        tick;
        tick;
        chk("rst_valid", 64'(bus.o_valid), 64'(0));
        chk("rst_coef", 64'(bus.o_coef), 64'(0));
        chk("rst_row", 64'(bus.o_row), 64'(0));
        chk("rst_last", 64'(bus.o_last), 64'(0));
        reset = 1'b1;
        tick;

        // table of single rows, row 0, lanes 0 and 1
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, pack_in(vecs[i].c0, vecs[i].c1, 0));
            tick;
            idle;
            tick;
            chk($sformatf("vec%0d_valid", i),
                64'(bus.o_valid), 64'(1));
            chk($sformatf("vec%0d_coef", i), 64'(bus.o_coef),
                pack_out(vecs[i].e0, vecs[i].e1));
            chk($sformatf("vec%0d_row", i), 64'(bus.o_row), 64'(0));
            chk($sformatf("vec%0d_last", i),
                64'(bus.o_last), 64'(0));
        end
        tick;

        // full block back-to-back; lane 7 of row 7 = 990 -> 10
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive(1'b1, c == 0,
                      c == 7 ? pack_in(0, 0, 990) : 96'(0));
            end else begin
                idle;
            end
            tick;
            if (c >= 1 && c <= 8) begin
                chk($sformatf("blk_valid%0d", c - 1),
                    64'(bus.o_valid), 64'(1));
                chk($sformatf("blk_row%0d", c - 1),
                    64'(bus.o_row), 64'(c - 1));
                chk($sformatf("blk_last%0d", c - 1),
                    64'(bus.o_last), 64'(c == 8));
            end
            if (c == 8) begin
                chk("blk_lane7", 64'(bus.o_coef[63:56]), 64'(10));
            end
            if (c == 9) begin
                chk("blk_end_valid", 64'(bus.o_valid), 64'(0));
                chk("blk_end_last", 64'(bus.o_last), 64'(0));
            end
        end

        // counter wrapped to 0; sof on 4th row restarts
        for (int c = 0; c < 6; c++) begin
            if (c < 5) begin
                drive(1'b1, sofs[c], '0);
            end else begin
                idle;
            end
            tick;
            if (c >= 1) begin
                chk($sformatf("rst_blk_row%0d", c - 1),
                    64'(bus.o_row), 64'(rexp[c-1]));
                chk($sformatf("rst_blk_last%0d", c - 1),
                    64'(bus.o_last), 64'(0));
            end
        end
        tick;

`ifdef DCTQ_TABLE_LOAD_EN
        // write during the row's capture cycle: old value used
        bus.tbl_we   = 1'b1;
        bus.tbl_addr = 6'd0;
        bus.tbl_data = 16'd32768;
        drive(1'b1, 1'b1, pack_in(100, 0, 0));
        tick;
        bus.tbl_we = 1'b0;
        idle;
        tick;
        chk("tbl_old", 64'(bus.o_coef), pack_out(6, 0));
        one_row("tbl_new", 100, 50);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        one_row("tbl_reset", 100, 6);
`else
        bus.tbl_we   = 1'b1;
        bus.tbl_addr = 6'd0;
        bus.tbl_data = 16'd32768;
        tick;
        bus.tbl_we = 1'b0;
        one_row("tbl_ignored", 100, 6);
`endif
        tick;

        // reset with two rows in flight
        drive(1'b1, 1'b1, pack_in(50, 0, 0));
        tick;
        drive(1'b1, 1'b0, pack_in(50, 0, 0));
        tick;
        idle;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("mid_rst_valid0", 64'(bus.o_valid), 64'(0));
        chk("mid_rst_coef0", 64'(bus.o_coef), 64'(0));
        tick;
        chk("mid_rst_valid1", 64'(bus.o_valid), 64'(0));
        drive(1'b1, 1'b0, pack_in(100, 0, 0));
        tick;
        idle;
        tick;
        chk("mid_rst_nvalid", 64'(bus.o_valid), 64'(1));
        chk("mid_rst_row", 64'(bus.o_row), 64'(0));
        chk("mid_rst_coef", 64'(bus.o_coef), pack_out(6, 0));
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
